// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the stream FIFOs
package fifo_pkg;

    typedef enum logic {
        START     = 1'b0,
        OPERATION = 1'b1
    } state_t;

    // Occupancy must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wrap_ptr_counter.sv
// rtl/wrap_ptr_counter.sv - circular buffer index that wraps DEPTH-1 -> 0
module wrap_ptr_counter #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     incr,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (incr) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/input_fifo.sv
// rtl/input_fifo.sv - AXI-Stream slave receive buffer drained by a rd_en strobe
module input_fifo
    import fifo_pkg::*;
#(
    parameter int INW   = 28,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INW-1:0]                AXIS_TDATA,
    input  logic                          AXIS_TVALID,
    output logic                          AXIS_TREADY,
    input  logic                          rd_en,
    output logic [INW-1:0]                data_out,
    output logic                          out_valid,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          empty,
    output logic                          full,
    output logic                          underflow_err
);

    localparam int CW = count_width(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [INW-1:0]  mem [DEPTH];
    logic            wr;
    logic            rd;
    logic            in_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= START;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            START:     state_nxt = OPERATION;
            OPERATION: state_nxt = OPERATION;
            default:   state_nxt = START;
        endcase
    end

    // Ready comes only from registered state so upstream sees no TVALID->TREADY path.
    always_comb begin
        in_start    = (state == START);
        AXIS_TREADY = (state == OPERATION) && (count < DEPTH_C);
        empty       = (count == '0);
        full        = (count == DEPTH_C);
    end

    assign wr = AXIS_TVALID && AXIS_TREADY;
    assign rd = (state == OPERATION) && rd_en && (count != '0);

    wrap_ptr_counter #(.DEPTH(DEPTH)) u_head (
        .clk   (clk),
        .reset (reset),
        .clr   (in_start),
        .incr  (wr),
        .ptr   (head)
    );

    wrap_ptr_counter #(.DEPTH(DEPTH)) u_tail (
        .clk   (clk),
        .reset (reset),
        .clr   (in_start),
        .incr  (rd),
        .ptr   (tail)
    );

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[head] <= AXIS_TDATA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out      <= '0;
            out_valid     <= 1'b0;
            underflow_err <= 1'b0;
            count         <= '0;
        end else begin
            out_valid <= rd;
            if (rd) begin
                data_out <= mem[tail];
            end
            if (rd_en && (count == '0)) begin
                underflow_err <= 1'b1;
            end
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
